rx_serial_7o1: RTL and testbench

Asynchronous serial receiver for 7-bit ASCII frames in 7O1 format: 1 start bit, 7 data bits LSB first, odd parity, 1 stop bit, at 115200 baud from a 50 MHz clock. It is the receiving end of the 7O1 serial link and pairs with the existing 7O1 transmitter on the same board. It samples each bit at mid-period and presents the assembled character with parity and framing status. A level/acknowledge handshake lets downstream logic consume the character.

---
 rtl/serial_7O1_pkg.sv | 31 +++
 rtl/contador_m.sv | 29 ++
 rtl/rx_serial_7o1_fd.sv | 82 ++++++++
 rtl/rx_serial_7o1.sv | 123 ++++++++++++
 tb/tb_rx_serial_7o1.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_7O1_pkg.sv
// Shared 7O1 serial link definitions (receiver and transmitter).
// State codes, frame constants, baud presets, parity sense.
package serial_7O1_pkg;

  localparam int DATA_BITS = 7;

  localparam int M_115200 = 434;
  localparam int N_115200 = 9;
  localparam int M_9600   = 5208;
  localparam int N_9600   = 13;

  // Odd parity: data bits plus parity bit hold an odd count of ones.
  localparam logic PARITY_ODD = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_START  = 4'd1,
    ST_DATA   = 4'd2,
    ST_PARITY = 4'd3,
    ST_STOP   = 4'd4,
    ST_DONE   = 4'd5
  } serial_state_t;

  function automatic logic parity_error(
    input logic [DATA_BITS-1:0] d,
    input logic                 p
  );
    return (^{d, p}) != PARITY_ODD;
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter with end-of-count and mid-count strobes.
// Ports: clock, reset, zera (sync clear), conta (enable), fim, meio.
module contador_m #(
  parameter int M = 434,
  parameter int N = 9
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim,
  output logic meio
);

  logic [N-1:0] q;

  assign fim  = (q == N'(M - 1));
  // Count M/2-1 lands on cycle M/2 after a clear.
  assign meio = (q == N'(M / 2 - 1));

  always_ff @(posedge clock) begin
    if (reset || zera) begin
      q <= '0;
    end else if (conta) begin
      q <= fim ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/rx_serial_7o1_fd.sv
// 7O1 receiver datapath: bit timer, shift register, status regs.
// Ports: clock, reset, linha, FSM controls in; tick, ultimo_bit,
// dados_ascii, pronto, tem_dado, erro_paridade, erro_stop out.
import serial_7O1_pkg::*;

module rx_serial_7O1_fd #(
  parameter int M = M_115200,
  parameter int N = N_115200
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 linha,
  input  logic                 zera,
  input  logic                 conta,
  input  logic                 desloca,
  input  logic                 captura_par,
  input  logic                 carrega,
  input  logic                 recebe,
  output logic                 tick,
  output logic                 ultimo_bit,
  output logic [DATA_BITS-1:0] dados_ascii,
  output logic                 pronto,
  output logic                 tem_dado,
  output logic                 erro_paridade,
  output logic                 erro_stop
);

  logic                 meio;
  logic                 fim;
  logic [DATA_BITS-1:0] sr;
  logic [2:0]           idx;
  logic                 par_bit;

  contador_m #(.M(M), .N(N)) u_cnt (
    .clock (clock),
    .reset (reset),
    .zera  (zera),
    .conta (conta),
    .fim   (fim),
    .meio  (meio)
  );

  assign tick       = conta & meio;
  assign ultimo_bit = (idx == 3'(DATA_BITS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      sr            <= '0;
      idx           <= '0;
      par_bit       <= 1'b0;
      dados_ascii   <= '0;
      pronto        <= 1'b0;
      tem_dado      <= 1'b0;
      erro_paridade <= 1'b0;
      erro_stop     <= 1'b0;
    end else begin
      if (zera) begin
        idx <= '0;
      end else if (desloca) begin
        idx <= idx + 1'b1;
      end
      // LSB first: first bit ends up in sr[0].
      if (desloca) begin
        sr <= {linha, sr[DATA_BITS-1:1]};
      end
      if (captura_par) begin
        par_bit <= linha;
      end
      pronto <= carrega;
      if (carrega) begin
        dados_ascii   <= sr;
        erro_paridade <= parity_error(sr, par_bit);
        erro_stop     <= ~linha;
        tem_dado      <= 1'b1;
      end else if (recebe && !pronto) begin
        // An ack coinciding with pronto loses to the new data.
        tem_dado <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rx_serial_7o1.sv
// 7O1 async serial receiver top: optional sync, FSM, datapath.
// Ports: clock, reset, dado_serial, recebe in; dados_ascii, pronto,
// tem_dado, erro_paridade, erro_stop, db_* debug out.
// Define RX_SERIAL_SYNC_EN to add a 2-flop input synchronizer.
import serial_7O1_pkg::*;

module rx_serial_7o1 #(
  parameter int M = M_115200,
  parameter int N = N_115200
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dado_serial,
  input  logic                 recebe,
  output logic [DATA_BITS-1:0] dados_ascii,
  output logic                 pronto,
  output logic                 tem_dado,
  output logic                 erro_paridade,
  output logic                 erro_stop,
  output logic                 db_tick,
  output logic                 db_dado_serial,
  output logic [3:0]           db_estado
);

  serial_state_t estado;
  serial_state_t prox;
  logic          linha;
  logic          tick;
  logic          ultimo_bit;
  logic          zera;
  logic          conta;
  logic          desloca;
  logic          captura_par;
  logic          carrega;

`ifdef RX_SERIAL_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], dado_serial};
    end
  end

  assign linha = sync_q[1];
`else
  assign linha = dado_serial;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= ST_IDLE;
    end else begin
      estado <= prox;
    end
  end

  always_comb begin
    prox        = estado;
    zera        = 1'b0;
    conta       = 1'b1;
    desloca     = 1'b0;
    captura_par = 1'b0;
    carrega     = 1'b0;
    unique case (estado)
      ST_IDLE: begin
        conta = 1'b0;
        zera  = 1'b1;
        if (!linha) prox = ST_START;
      end
      ST_START: begin
        if (tick) prox = linha ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          desloca = 1'b1;
          if (ultimo_bit) prox = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (tick) begin
          captura_par = 1'b1;
          prox        = ST_STOP;
        end
      end
      ST_STOP: begin
        // Outputs load here so they are valid in the DONE cycle.
        if (tick) begin
          carrega = 1'b1;
          prox    = ST_DONE;
        end
      end
      ST_DONE: prox = ST_IDLE;
      default: prox = ST_IDLE;
    endcase
  end

  rx_serial_7O1_fd #(.M(M), .N(N)) u_fd (
    .clock         (clock),
    .reset         (reset),
    .linha         (linha),
    .zera          (zera),
    .conta         (conta),
    .desloca       (desloca),
    .captura_par   (captura_par),
    .carrega       (carrega),
    .recebe        (recebe),
    .tick          (tick),
    .ultimo_bit    (ultimo_bit),
    .dados_ascii   (dados_ascii),
    .pronto        (pronto),
    .tem_dado      (tem_dado),
    .erro_paridade (erro_paridade),
    .erro_stop     (erro_stop)
  );

  assign db_tick        = tick;
  assign db_dado_serial = linha;
  assign db_estado      = estado;

endmodule

// File: tb/tb_rx_serial_7o1.sv
// Self-checking bench for rx_serial_7o1 against a frame-level model.
// Ports: none (drives clock, reset, dado_serial, recebe).
module tb_rx_serial_7o1;

  localparam int BIT  = 434;
  localparam int FRM  = 10 * BIT;
  localparam int MID  = BIT / 2;
  localparam int DONE = MID + 9 * BIT + 1;
`ifdef RX_SERIAL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       dado_serial = 1'b1;
  logic       recebe = 1'b0;
  logic [6:0] dados_ascii;
  logic       pronto, tem_dado;
  logic       erro_paridade, erro_stop;
  logic       db_tick, db_dado_serial;
  logic [3:0] db_estado;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    int         c;
    logic [6:0] d;
    logic       ep;
    logic       es;
    logic       td;
  } ev_t;

  ev_t mon_e;
  ev_t pr_q[$];
  int  tick_q[$];

  rx_serial_7o1 dut (
    .clock          (clock),
    .reset          (reset),
    .dado_serial    (dado_serial),
    .recebe         (recebe),
    .dados_ascii    (dados_ascii),
    .pronto         (pronto),
    .tem_dado       (tem_dado),
    .erro_paridade  (erro_paridade),
    .erro_stop      (erro_stop),
    .db_tick        (db_tick),
    .db_dado_serial (db_dado_serial),
    .db_estado      (db_estado)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (db_tick) tick_q.push_back(cyc);
    if (pronto) begin
      mon_e.c  = cyc;
      mon_e.d  = dados_ascii;
      mon_e.ep = erro_paridade;
      mon_e.es = erro_stop;
      mon_e.td = tem_dado;
      pr_q.push_back(mon_e);
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clock); #1;
      dado_serial = 1'b1;
      recebe      = 1'b0;
    end
  endtask

  // Drives cycles 0..stop_at-1 of a frame; c0 is the cycle number
  // in which the start bit first appears on the line.
  task automatic send_frame(
    input  logic [6:0] d,
    input  logic       p,
    input  logic       s,
    input  int         stop_at,
    input  int         recebe_at,
    output int         c0
  );
    logic [9:0] bits;
    bits = {s, p, d, 1'b0};
    tick_q.delete();
    pr_q.delete();
    @(posedge clock); #1;
    c0 = cyc;
    for (int n = 0; n < stop_at; n++) begin
      if (n > 0) begin
        @(posedge clock); #1;
      end
      dado_serial = bits[n / BIT];
      recebe      = (n == recebe_at);
    end
  endtask

  function automatic logic exp_ep(input logic [6:0] d, input logic p);
    return ($countones({d, p}) % 2) == 0;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    @(negedge clock);
    n_cmp++;
    if (dados_ascii !== 7'h00) begin
      n_err++;
      $display("FAIL reset_data got %h want 00", dados_ascii);
    end
    n_cmp++;
    if ({pronto, tem_dado, erro_paridade, erro_stop, db_tick}
        !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags got %b want 00000",
        {pronto, tem_dado, erro_paridade, erro_stop, db_tick});
    end
    n_cmp++;
    if (db_estado !== 4'd0) begin
      n_err++;
      $display("FAIL reset_state got %0d want 0", db_estado);
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_frames;
    logic [6:0] d;
    logic       p, s;
    int         c0;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin d = 7'h41; p = 1'b1; s = 1'b1; end
        1: begin d = 7'h41; p = 1'b0; s = 1'b1; end
        2: begin d = 7'h7F; p = 1'b0; s = 1'b0; end
        default: begin
          d = 7'($urandom_range(0, 127));
          p = 1'($urandom_range(0, 1));
          s = ($urandom_range(0, 3) != 0);
        end
      endcase
      send_frame(d, p, s, FRM, -1, c0);
      @(negedge clock);
      n_cmp++;
      if (pr_q.size() != 1) begin
        n_err++;
        $display("FAIL frame%0d_pronto_count got %0d want 1",
          i, pr_q.size());
      end else begin
        n_cmp++;
        if (pr_q[0].c != c0 + DONE + LAT) begin
          n_err++;
          $display("FAIL frame%0d_pronto_time got %0d want %0d",
            i, pr_q[0].c - c0, DONE + LAT);
        end
        n_cmp++;
        if (pr_q[0].d !== d) begin
          n_err++;
          $display("FAIL frame%0d_data got %h want %h",
            i, pr_q[0].d, d);
        end
        n_cmp++;
        if (pr_q[0].ep !== exp_ep(d, p)) begin
          n_err++;
          $display("FAIL frame%0d_parity got %b want %b",
            i, pr_q[0].ep, exp_ep(d, p));
        end
        n_cmp++;
        if (pr_q[0].es !== ~s) begin
          n_err++;
          $display("FAIL frame%0d_stop got %b want %b",
            i, pr_q[0].es, ~s);
        end
        n_cmp++;
        if (pr_q[0].td !== 1'b1) begin
          n_err++;
          $display("FAIL frame%0d_tem_dado got %b want 1",
            i, pr_q[0].td);
        end
      end
      n_cmp++;
      if (tick_q.size() != 10) begin
        n_err++;
        $display("FAIL frame%0d_tick_count got %0d want 10",
          i, tick_q.size());
      end else begin
        for (int k = 0; k < 10; k++) begin
          n_cmp++;
          if (tick_q[k] != c0 + MID + k * BIT + LAT) begin
            n_err++;
            $display("FAIL frame%0d_tick%0d got %0d want %0d",
              i, k, tick_q[k] - c0, MID + k * BIT + LAT);
          end
        end
      end
      @(posedge clock); #1;
      dado_serial = 1'b1;
      recebe      = 1'b1;
      @(posedge clock); #1;
      recebe      = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (tem_dado !== 1'b0 || dados_ascii !== d) begin
        n_err++;
        $display("FAIL frame%0d_ack got td=%b d=%h want td=0 d=%h",
          i, tem_dado, dados_ascii, d);
      end
      idle(600);
    end
  endtask

  task automatic test_false_start;
    logic [6:0] d0;
    logic       ep0, es0;
    int         c0;
    d0  = dados_ascii;
    ep0 = erro_paridade;
    es0 = erro_stop;
    tick_q.delete();
    pr_q.delete();
    @(posedge clock); #1;
    c0 = cyc;
    for (int n = 0; n < 500; n++) begin
      if (n > 0) begin
        @(posedge clock); #1;
      end
      dado_serial = (n >= 100);
      if (n == MID - 1 + LAT) begin
        @(negedge clock);
        n_cmp++;
        if (db_estado !== 4'd1) begin
          n_err++;
          $display("FAIL fs_in_start got %0d want 1", db_estado);
        end
      end
      if (n == MID + 1 + LAT) begin
        @(negedge clock);
        n_cmp++;
        if (db_estado !== 4'd0) begin
          n_err++;
          $display("FAIL fs_back_idle got %0d want 0", db_estado);
        end
      end
    end
    @(negedge clock);
    n_cmp++;
    if (pr_q.size() != 0 || tick_q.size() != 1) begin
      n_err++;
      $display("FAIL fs_events got pronto=%0d ticks=%0d want 0/1",
        pr_q.size(), tick_q.size());
    end
    n_cmp++;
    if ({dados_ascii, erro_paridade, erro_stop, tem_dado}
        !== {d0, ep0, es0, 1'b0}) begin
      n_err++;
      $display("FAIL fs_outputs got %h/%b%b%b want %h/%b%b0",
        dados_ascii, erro_paridade, erro_stop, tem_dado,
        d0, ep0, es0);
    end
    n_cmp++;
    if (tick_q.size() == 1 && tick_q[0] != c0 + MID + LAT) begin
      n_err++;
      $display("FAIL fs_tick_time got %0d want %0d",
        tick_q[0] - c0, MID + LAT);
    end
  endtask

  task automatic test_reset_mid;
    int c0;
    send_frame(7'h2A, 1'b0, 1'b1, FRM, -1, c0);
    idle(300);
    send_frame(7'h63, 1'b1, 1'b1, 2000, -1, c0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset       = 1'b0;
    dado_serial = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({dados_ascii, pronto, tem_dado, erro_paridade, erro_stop,
         db_tick, db_estado} !== 16'h0) begin
      n_err++;
      $display("FAIL midreset_outputs got %h/%b%b%b%b%b/%0d want 0",
        dados_ascii, pronto, tem_dado, erro_paridade, erro_stop,
        db_tick, db_estado);
    end
    idle(4500);
    n_cmp++;
    if (pr_q.size() != 0) begin
      n_err++;
      $display("FAIL midreset_no_pronto got %0d want 0", pr_q.size());
    end
    send_frame(7'h55, 1'b1, 1'b1, FRM, -1, c0);
    @(negedge clock);
    n_cmp++;
    if (pr_q.size() != 1) begin
      n_err++;
      $display("FAIL postreset_count got %0d want 1", pr_q.size());
    end else if (pr_q[0].c != c0 + DONE + LAT || pr_q[0].d !== 7'h55
                 || pr_q[0].ep !== 1'b0 || pr_q[0].es !== 1'b0) begin
      n_err++;
      $display("FAIL postreset_frame got t=%0d d=%h ep=%b es=%b want t=%0d d=55 ep=0 es=0",
        pr_q[0].c - c0, pr_q[0].d, pr_q[0].ep, pr_q[0].es,
        DONE + LAT);
    end
    idle(300);
  endtask

  task automatic test_back_to_back;
    logic [6:0] d1, d2;
    int         c0, c1;
    d1 = 7'($urandom_range(0, 127));
    d2 = ~d1;
    send_frame(d1, ~^d1, 1'b1, FRM, -1, c0);
    n_cmp++;
    if (pr_q.size() != 1 || pr_q[0].d !== d1) begin
      n_err++;
      $display("FAIL b2b_first got n=%0d want 1 frame of %h",
        pr_q.size(), d1);
    end
    send_frame(d2, ~^d2, 1'b1, FRM, DONE + LAT, c1);
    @(negedge clock);
    n_cmp++;
    if (pr_q.size() != 1) begin
      n_err++;
      $display("FAIL b2b_second_count got %0d want 1", pr_q.size());
    end else if (pr_q[0].c != c1 + DONE + LAT || pr_q[0].d !== d2
                 || pr_q[0].ep !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second got t=%0d d=%h ep=%b want t=%0d d=%h ep=0",
        pr_q[0].c - c1, pr_q[0].d, pr_q[0].ep, DONE + LAT, d2);
    end
    n_cmp++;
    if (tem_dado !== 1'b1 || dados_ascii !== d2) begin
      n_err++;
      $display("FAIL b2b_hold got td=%b d=%h want td=1 d=%h",
        tem_dado, dados_ascii, d2);
    end
    idle(50);
  endtask

  initial begin
    test_reset();
    test_frames();
    test_false_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end

endmodule
